// File: rtl/fanbit_pipe_rca.sv
// fanbit_pipe_rca: SIZE-bit ripple-carry adder/subtractor split into STAGES registered segments
// with a valid/ready handshake and bubble collapsing. Macro FANBIT_PIPE_OVF_EN adds output Ovf.
module fanbit_pipe_rca #(
   parameter int SIZE   = 16,
   parameter int STAGES = 4
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic [SIZE-1:0] Port_A,
   input  logic [SIZE-1:0] Port_B,
   input  logic            Cin,
   input  logic            Sub,
   input  logic            In_Valid,
   output logic            In_Ready,
   output logic [SIZE-1:0] Port_Sum,
   output logic            Cout,
   output logic            Out_Valid,
   input  logic            Out_Ready
`ifdef FANBIT_PIPE_OVF_EN
   ,
   output logic            Ovf
`endif
);

   localparam int SEG  = SIZE / STAGES;
   localparam int LAST = STAGES - 1;

   // Bit-serial ripple of one segment; returns {carry_out, sum}.
   function automatic logic [SEG:0] rca_seg(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           ci);
      logic           c;
      logic [SEG-1:0] s;
      c = ci;
      s = {SEG{1'b0}};
      for (int k = 0; k < SEG; k++) begin
         s[k] = a[k] ^ b[k] ^ c;
         c    = (a[k] & b[k]) | (a[k] & c) | (b[k] & c);
      end
      return {c, s};
   endfunction

   // Keeps only the operand bits that later stages still have to add.
   function automatic logic [SIZE-1:0] upper_mask(input int stage);
      return {SIZE{1'b1}} << ((stage + 1) * SEG);
   endfunction

   logic [STAGES-1:0] v_r;
   logic [STAGES-1:0] c_r;
   logic [SIZE-1:0]   a_r   [STAGES];
   logic [SIZE-1:0]   b_r   [STAGES];
   logic [SIZE-1:0]   sum_r [STAGES];

   logic [SIZE-1:0]   a_in_s    [STAGES];
   logic [SIZE-1:0]   b_in_s    [STAGES];
   logic [SIZE-1:0]   sum_in_s  [STAGES];
   logic [STAGES-1:0] c_in_s;
   logic [STAGES-1:0] v_in_s;
   logic [SIZE-1:0]   a_nxt_s   [STAGES];
   logic [SIZE-1:0]   b_nxt_s   [STAGES];
   logic [SIZE-1:0]   sum_nxt_s [STAGES];
   logic [STAGES-1:0] c_nxt_s;
   logic [SEG:0]      seg_s;

   logic [STAGES-1:0] load_s;
   logic              full_acc_s;

`ifdef FANBIT_PIPE_OVF_EN
   logic              ovf_nxt_s;
   logic              ovf_r;
`endif

   // Per-stage datapath: select stage inputs, ripple this stage's segment, form next register values.
   always_comb begin
      a_in_s[0]   = Port_A;
      b_in_s[0]   = Port_B ^ {SIZE{Sub}};
      sum_in_s[0] = {SIZE{1'b0}};
      c_in_s[0]   = Cin ^ Sub;
      v_in_s[0]   = In_Valid;
      for (int i = 1; i < STAGES; i++) begin
         a_in_s[i]   = a_r[i-1];
         b_in_s[i]   = b_r[i-1];
         sum_in_s[i] = sum_r[i-1];
         c_in_s[i]   = c_r[i-1];
         v_in_s[i]   = v_r[i-1];
      end
      seg_s = {(SEG+1){1'b0}};
      for (int i = 0; i < STAGES; i++) begin
         seg_s        = rca_seg(a_in_s[i][i*SEG +: SEG], b_in_s[i][i*SEG +: SEG], c_in_s[i]);
         sum_nxt_s[i] = sum_in_s[i];
         sum_nxt_s[i][i*SEG +: SEG] = seg_s[SEG-1:0];
         c_nxt_s[i]   = seg_s[SEG];
         a_nxt_s[i]   = a_in_s[i] & upper_mask(i);
         b_nxt_s[i]   = b_in_s[i] & upper_mask(i);
      end
   end

`ifdef FANBIT_PIPE_OVF_EN
   // Carry into the MSB is recovered as a^b^sum at the MSB, then XORed with the final carry.
   always_comb begin
      ovf_nxt_s = a_in_s[LAST][SIZE-1] ^ b_in_s[LAST][SIZE-1]
                ^ sum_nxt_s[LAST][SIZE-1] ^ c_nxt_s[LAST];
   end
`endif

   // A stage loads if it, or any stage after it, is empty, or the consumer is taking the result.
   always_comb begin
      full_acc_s = 1'b1;
      load_s     = {STAGES{1'b0}};
      for (int i = STAGES - 1; i >= 0; i--) begin
         full_acc_s = full_acc_s & v_r[i];
         load_s[i]  = Out_Ready | ~full_acc_s;
      end
   end

   // Pipeline registers; data only moves when a valid operand set advances into the stage.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         v_r <= {STAGES{1'b0}};
         c_r <= {STAGES{1'b0}};
         for (int i = 0; i < STAGES; i++) begin
            a_r[i]   <= {SIZE{1'b0}};
            b_r[i]   <= {SIZE{1'b0}};
            sum_r[i] <= {SIZE{1'b0}};
         end
`ifdef FANBIT_PIPE_OVF_EN
         ovf_r <= 1'b0;
`endif
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (load_s[i]) begin
               v_r[i] <= v_in_s[i];
               if (v_in_s[i]) begin
                  a_r[i]   <= a_nxt_s[i];
                  b_r[i]   <= b_nxt_s[i];
                  sum_r[i] <= sum_nxt_s[i];
                  c_r[i]   <= c_nxt_s[i];
               end
            end
         end
`ifdef FANBIT_PIPE_OVF_EN
         if (load_s[LAST] && v_in_s[LAST]) begin
            ovf_r <= ovf_nxt_s;
         end
`endif
      end
   end

   assign In_Ready  = load_s[0] & ~Rst;
   assign Port_Sum  = sum_r[LAST];
   assign Cout      = c_r[LAST];
   assign Out_Valid = v_r[LAST];
`ifdef FANBIT_PIPE_OVF_EN
   assign Ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_fanbit_pipe_rca.sv
// tb_fanbit_pipe_rca: table-driven and directed-sequence bench for fanbit_pipe_rca (SIZE=16, STAGES=4).
module tb_fanbit_pipe_rca;

   localparam int SIZE   = 16;
   localparam int STAGES = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [SIZE-1:0]   port_a;
   logic [SIZE-1:0]   port_b;
   logic              cin;
   logic              sub;
   logic              in_valid;
   logic              in_ready;
   logic [SIZE-1:0]   port_sum;
   logic              cout;
   logic              out_valid;
   logic              out_ready;
`ifdef FANBIT_PIPE_OVF_EN
   logic              ovf;
`endif

   always #5 clk = ~clk;

   fanbit_pipe_rca #(.SIZE(SIZE), .STAGES(STAGES)) dut (
      .Clk      (clk),
      .Rst      (rst),
      .Port_A   (port_a),
      .Port_B   (port_b),
      .Cin      (cin),
      .Sub      (sub),
      .In_Valid (in_valid),
      .In_Ready (in_ready),
      .Port_Sum (port_sum),
      .Cout     (cout),
      .Out_Valid(out_valid),
      .Out_Ready(out_ready)
`ifdef FANBIT_PIPE_OVF_EN
      ,
      .Ovf      (ovf)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   vec_t vecs [16];
   res_t sb [$];
   res_t drv_exp;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: plain 17-bit integer add, overflow from operand/result signs.
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic s);
      res_t        r;
      logic [15:0] be;
      logic [16:0] t;
      be     = b ^ {16{s}};
      t      = {1'b0, a} + {1'b0, be} + {16'h0000, c ^ s};
      r.sum  = t[15:0];
      r.cout = t[16];
      r.ovf  = (a[15] == be[15]) && (t[15] != a[15]);
      return r;
   endfunction

   task automatic present(input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input res_t e);
      port_a   = a;
      port_b   = b;
      cin      = c;
      sub      = s;
      drv_exp  = e;
      in_valid = 1'b1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Called at a falling edge: score the output side, record an accepted input, advance one cycle.
   task automatic step();
      #1;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_out_valid", out_valid, 1'b0);
         end else begin
            check("out_sum", port_sum, sb[0].sum);
            check("out_cout", cout, sb[0].cout);
`ifdef FANBIT_PIPE_OVF_EN
            check("out_ovf", ovf, sb[0].ovf);
`endif
            if (out_ready) void'(sb.pop_front());
         end
      end
      if (in_valid && in_ready) sb.push_back(drv_exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 20 && sb.size() > 0; k++) step();
      check({name, "_drained"}, sb.size(), 0);
   endtask

   // Operands are presented before the 1st edge; Out_Valid must rise only after the 4th edge.
   task automatic latency_check(input string name, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input logic s,
                                input logic [15:0] exp_sum, input logic exp_cout);
      res_t e;
      e.sum  = exp_sum;
      e.cout = exp_cout;
      e.ovf  = model(a, b, c, s).ovf;
      present(a, b, c, s, e);
      step();
      idle();
      for (int edge_n = 1; edge_n <= STAGES; edge_n++) begin
         check({name, "_out_valid"}, out_valid, (edge_n == STAGES) ? 1'b1 : 1'b0);
         if (edge_n < STAGES) step();
      end
      check({name, "_sum"}, port_sum, exp_sum);
      check({name, "_cout"}, cout, exp_cout);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
      vecs[3]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
      vecs[4]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
      vecs[5]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[10] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[11] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[12] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[13] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[14] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[15] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};

      rst       = 1'b1;
      port_a    = 16'h0000;
      port_b    = 16'h0000;
      cin       = 1'b0;
      sub       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drv_exp   = '{16'h0000, 1'b0, 1'b0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", port_sum, 16'h0000);
      check("rst_cout", cout, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
`ifdef FANBIT_PIPE_OVF_EN
      check("rst_ovf", ovf, 1'b0);
`endif
      rst = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1'b1);
      @(negedge clk);

      // Latency and the two directed arithmetic cases
      latency_check("lat_add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
      latency_check("lat_sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
      latency_check("lat_sub_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0);

      // Streaming: table vectors then generated small-operand ops, back to back
      for (int k = 0; k < 32; k++) begin
         logic [15:0] a;
         logic [15:0] b;
         logic        c;
         logic        s;
         res_t        e;
         if (k < 16) begin
            a = vecs[k].a;
            b = vecs[k].b;
            c = vecs[k].cin;
            s = vecs[k].sub;
            e = '{vecs[k].sum, vecs[k].cout, vecs[k].ovf};
         end else begin
            a = 16'(k - 16);
            b = 16'(31 - k);
            c = k[0];
            s = k[1];
            e = model(a, b, c, s);
         end
         present(a, b, c, s, e);
         #1;
         check("stream_in_ready", in_ready, 1'b1);
         check("stream_out_valid", out_valid, (k >= STAGES) ? 1'b1 : 1'b0);
         step();
      end
      idle();
      drain("stream");

      // Sparse input, then a 6-cycle output stall that must fill all 4 stages
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) present(16'h0100 + 16'(k), 16'h0010 * 16'(k + 1), 1'b0, k[1],
                                 model(16'h0100 + 16'(k), 16'h0010 * 16'(k + 1), 1'b0, k[1]));
         else idle();
         step();
      end
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         present(16'h2000 + 16'(k * 3), 16'h0101, k[0], 1'b0,
                 model(16'h2000 + 16'(k * 3), 16'h0101, k[0], 1'b0));
         #1;
         check("bp_in_ready", in_ready, (sb.size() < STAGES) ? 1'b1 : 1'b0);
         step();
      end
      check("bp_fill", sb.size(), STAGES);
      check("bp_out_valid", out_valid, 1'b1);
      idle();
      out_ready = 1'b1;
      drain("bp");

      // Reset with three operations in flight
      for (int k = 0; k < 3; k++) begin
         present(16'h0F00 + 16'(k), 16'h00F0, 1'b0, 1'b0, model(16'h0F00 + 16'(k), 16'h00F0, 1'b0, 1'b0));
         step();
      end
      idle();
      rst = 1'b1;
      step();
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_sum", port_sum, 16'h0000);
      check("mid_rst_cout", cout, 1'b0);
      sb.delete();
      rst = 1'b0;
      latency_check("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
      for (int k = 0; k < 3; k++) step();
      check("post_rst_quiet", out_valid, 1'b0);

`ifdef FANBIT_PIPE_OVF_EN
      for (int k = 0; k < 3; k++) begin
         logic [15:0] a;
         logic [15:0] b;
         logic        s;
         logic        exp_ovf;
         case (k)
            0:       begin a = 16'h7FFF; b = 16'h0001; s = 1'b0; exp_ovf = 1'b1; end
            1:       begin a = 16'h8000; b = 16'h0001; s = 1'b1; exp_ovf = 1'b1; end
            default: begin a = 16'h0003; b = 16'h0004; s = 1'b0; exp_ovf = 1'b0; end
         endcase
         present(a, b, 1'b0, s, model(a, b, 1'b0, s));
         step();
         idle();
         for (int e = 1; e < STAGES; e++) step();
         check("ovf_dir", ovf, exp_ovf);
         step();
      end
`endif

      check("final_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
